// File: rtl/data_mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_access_pkg
// Brief   : Shared load-type codes, store masks and FSM states for the
//           data-memory access block.
// Revision: 1.0
// ============================================================================
package data_mem_access_pkg;

  typedef enum logic [2:0] {
    LT_NONE = 3'd0,
    LT_LB   = 3'd1,
    LT_LH   = 3'd2,
    LT_LW   = 3'd3,
    LT_LBU  = 3'd4,
    LT_LHU  = 3'd5
  } load_type_e;

  localparam logic [3:0] C_SM_NONE = 4'b0000;
  localparam logic [3:0] C_SM_SB   = 4'b0001;
  localparam logic [3:0] C_SM_SH   = 4'b0011;
  localparam logic [3:0] C_SM_SW   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_access_if.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_access_if
// Brief   : Request/acknowledge bus between the MEM stage and data memory.
// Revision: 1.0
// ============================================================================
interface data_mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_access_load_extend.sv
`default_nettype none
// ============================================================================
// Module  : load_extend
// Brief   : Selects the addressed byte/halfword of a read word and extends it.
// Revision: 1.0
// ============================================================================
module load_extend
  import data_mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  type_i,
  output logic [31:0] result_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word_i[7:0];
    case (offset_i)
      2'd1:    w_byte = word_i[15:8];
      2'd2:    w_byte = word_i[23:16];
      2'd3:    w_byte = word_i[31:24];
      default: w_byte = word_i[7:0];
    endcase
    w_half = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    result_o = '0;
    case (type_i)
      LT_LB:   result_o = {{24{w_byte[7]}}, w_byte};
      LT_LH:   result_o = {{16{w_half[15]}}, w_half};
      LT_LW:   result_o = word_i;
      LT_LBU:  result_o = {24'b0, w_byte};
      LT_LHU:  result_o = {16'b0, w_half};
      default: result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_access.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_access
// Brief   : MEM-stage data-memory access FSM with store alignment, load
//           extension, misalignment detection and pipeline stall.
// Revision: 1.0
// ============================================================================
module data_mem_access
  import data_mem_access_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              AluOutM,
  input  logic [31:0]              StoreDataM,
  input  logic [3:0]               MemWriteM,
  input  logic                     MemToRegM,
  input  logic [2:0]               RegWriteM,
  output logic                     DmStall,
  output logic [31:0]              DmRdataM,
  output logic                     DmDoneM,
  output logic                     MisalignM,
  data_mem_access_if.master        mem
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [2:0]  ltype_q;
  logic [1:0]  off_q;

  logic        w_is_store, w_pending, w_misalign, w_issue;
  logic        w_stall, w_misalign_pulse;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;

  // A store mask wins over MemToRegM when both are present.
  always_comb begin
    w_is_store = (MemWriteM != C_SM_NONE);
    w_pending  = w_is_store || MemToRegM;
    w_misalign = 1'b0;
    if (w_is_store) begin
      if (MemWriteM == C_SM_SH)      w_misalign = AluOutM[0];
      else if (MemWriteM == C_SM_SW) w_misalign = (AluOutM[1:0] != 2'b00);
    end else if (MemToRegM) begin
      case (RegWriteM)
        LT_LH, LT_LHU: w_misalign = AluOutM[0];
        LT_LW:         w_misalign = (AluOutM[1:0] != 2'b00);
        default:       w_misalign = 1'b0;
      endcase
    end
    w_be    = MemWriteM << AluOutM[1:0];
    w_wdata = StoreDataM << {AluOutM[1:0], 3'b000};
  end

  always_comb begin
    state_d          = state_q;
    w_stall          = 1'b0;
    w_misalign_pulse = 1'b0;
    w_issue          = 1'b0;
    DmDoneM          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_pending) begin
          if (w_misalign) begin
            w_misalign_pulse = 1'b1;
          end else begin
            w_stall = 1'b1;
            w_issue = 1'b1;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (mem.mem_ack) state_d = S_DONE;
      end
      // The instruction still sitting in MEM is the one just served.
      S_DONE: begin
        DmDoneM = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Combinational IDLE outputs must still read 0 while reset is held.
  assign DmStall   = w_stall & rst_n;
  assign MisalignM = w_misalign_pulse & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      ltype_q <= LT_NONE;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (w_issue) begin
        addr_q  <= {AluOutM[31:2], 2'b00};
        we_q    <= w_is_store;
        be_q    <= w_is_store ? w_be : 4'b0000;
        wdata_q <= w_is_store ? w_wdata : 32'h0;
        ltype_q <= w_is_store ? LT_NONE : RegWriteM;
        off_q   <= AluOutM[1:0];
      end
      if ((state_q == S_BUSY) && mem.mem_ack) rdata_q <= w_ext;
    end
  end

  load_extend u_load_extend (
    .word_i   (mem.mem_rdata),
    .offset_i (off_q),
    .type_i   (ltype_q),
    .result_o (w_ext)
  );

  assign mem.mem_req   = (state_q == S_BUSY);
  assign mem.mem_we    = (state_q == S_BUSY) ? we_q    : 1'b0;
  assign mem.mem_addr  = (state_q == S_BUSY) ? addr_q  : 32'h0;
  assign mem.mem_be    = (state_q == S_BUSY) ? be_q    : 4'b0000;
  assign mem.mem_wdata = (state_q == S_BUSY) ? wdata_q : 32'h0;
  assign DmRdataM      = (state_q == S_DONE) ? rdata_q : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_access
// Brief   : Directed and random accesses compared against a transaction model.
// Revision: 1.0
// ============================================================================
module tb_data_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] AluOutM = '0, StoreDataM = '0;
  logic [3:0]  MemWriteM = '0;
  logic        MemToRegM = 1'b0;
  logic [2:0]  RegWriteM = '0;
  logic        DmStall, DmDoneM, MisalignM;
  logic [31:0] DmRdataM;

  data_mem_access_if mem_if();

  data_mem_access dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .AluOutM    (AluOutM),
    .StoreDataM (StoreDataM),
    .MemWriteM  (MemWriteM),
    .MemToRegM  (MemToRegM),
    .RegWriteM  (RegWriteM),
    .DmStall    (DmStall),
    .DmRdataM   (DmRdataM),
    .DmDoneM    (DmDoneM),
    .MisalignM  (MisalignM),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_on = 1'b0;
  logic        exp_stall, exp_done, exp_mis, exp_req, exp_zero_bus, exp_we, exp_chk_rd;
  logic [31:0] exp_addr, exp_wdata, exp_result;
  logic [3:0]  exp_be;

  int          stall_cnt, mis_cnt, req_cnt;
  logic [31:0] obs_addr, obs_wdata, obs_result;
  logic [3:0]  obs_be;
  logic        obs_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Bytes needed for the access; an address not divisible by it is misaligned.
  function automatic int access_size(input logic [3:0] mask, input logic [2:0] lt);
    if (mask != 4'b0) return (mask == 4'b1111) ? 4 : (mask == 4'b0011) ? 2 : 1;
    if (lt == 3'd2 || lt == 3'd5) return 2;
    if (lt == 3'd3) return 4;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input logic [2:0] lt);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (8 * (off - off % 2))) & 32'hFFFF;
    case (lt)
      3'd1:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd2:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd3:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (exp_on) begin
      chk("DmStall",   32'(DmStall),        32'(exp_stall));
      chk("DmDoneM",   32'(DmDoneM),        32'(exp_done));
      chk("MisalignM", 32'(MisalignM),      32'(exp_mis));
      chk("mem_req",   32'(mem_if.mem_req), 32'(exp_req));
      if (exp_req) begin
        chk("mem_we",   32'(mem_if.mem_we), 32'(exp_we));
        chk("mem_addr", mem_if.mem_addr,    exp_addr);
        chk("mem_be",   32'(mem_if.mem_be), 32'(exp_be));
        if (exp_we) chk("mem_wdata", mem_if.mem_wdata, exp_wdata);
      end
      if (exp_zero_bus) begin
        chk("idle_we",    32'(mem_if.mem_we), 32'h0);
        chk("idle_addr",  mem_if.mem_addr,    32'h0);
        chk("idle_be",    32'(mem_if.mem_be), 32'h0);
        chk("idle_wdata", mem_if.mem_wdata,   32'h0);
      end
      if (exp_done && exp_chk_rd) chk("DmRdataM", DmRdataM, exp_result);
    end
    if (DmStall)   stall_cnt++;
    if (MisalignM) mis_cnt++;
    if (mem_if.mem_req) begin
      req_cnt++;
      obs_addr  = mem_if.mem_addr;
      obs_be    = mem_if.mem_be;
      obs_we    = mem_if.mem_we;
      obs_wdata = mem_if.mem_wdata;
    end
    if (DmDoneM) obs_result = DmRdataM;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic stall, input logic req, input logic done,
                         input logic mis, input logic zero_bus);
    exp_stall = stall; exp_req = req; exp_done = done; exp_mis = mis; exp_zero_bus = zero_bus;
  endtask

  // Presents one MEM-stage instruction and plays the memory with ack in the
  // lat-th request cycle; the instruction stays in MEM until it is released.
  task automatic run_op(input logic [31:0] addr, input logic [31:0] sdata, input logic [3:0] mask,
                        input logic mtr, input logic [2:0] lt, input int lat, input logic [31:0] word);
    logic is_st, pend, misal;
    int   off;
    is_st = (mask != 4'b0);
    pend  = is_st || mtr;
    off   = int'(addr[1:0]);
    misal = pend && ((addr % access_size(mask, lt)) != 0);
    stall_cnt = 0; mis_cnt = 0; req_cnt = 0;
    obs_addr = '0; obs_be = '0; obs_we = 1'b0; obs_wdata = '0; obs_result = '0;
    AluOutM = addr; StoreDataM = sdata; MemWriteM = mask; MemToRegM = mtr; RegWriteM = lt;
    exp_addr   = addr - (addr % 4);
    exp_we     = is_st;
    exp_be     = is_st ? 4'((int'(mask) * (1 << off)) % 16) : 4'b0;
    exp_wdata  = sdata * (32'd1 << (8 * off));
    exp_chk_rd = !is_st;
    exp_result = model_load(word, off, lt);
    mem_if.mem_ack   = 1'($urandom % 2);
    mem_if.mem_rdata = $urandom;
    if (!pend || misal) begin
      set_exp(1'b0, 1'b0, 1'b0, misal, 1'b1);
      step();
    end else begin
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      for (int k = 1; k <= lat; k++) begin
        set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        mem_if.mem_ack   = (k == lat);
        mem_if.mem_rdata = (k == lat) ? word : $urandom;
        step();
      end
      set_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      mem_if.mem_ack   = 1'($urandom % 2);
      mem_if.mem_rdata = $urandom;
      step();
    end
  endtask

  initial begin
    logic [31:0] addr, sdata, word;
    logic [3:0]  mask;
    logic [2:0]  lt;
    logic        mtr;
    int          lat, kind, sz;

    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 32'hFFFF_FFFF;
    // Pending aligned load held during reset: nothing may leak out.
    AluOutM = 32'h0000_1000; MemToRegM = 1'b1; RegWriteM = 3'd3;
    repeat (3) step();
    chk("rst_req",    32'(mem_if.mem_req), 32'h0);
    chk("rst_stall",  32'(DmStall),        32'h0);
    chk("rst_done",   32'(DmDoneM),        32'h0);
    chk("rst_mis",    32'(MisalignM),      32'h0);
    chk("rst_rdata",  DmRdataM,            32'h0);
    rst_n = 1'b1;
    exp_on = 1'b1;

    run_op(32'h0000_1000, 32'h0, 4'b0000, 1'b1, 3'd3, 1, 32'hDEAD_BEEF);
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd2);
    chk("lw_result",       obs_result,     32'hDEAD_BEEF);
    chk("lw_be",           32'(obs_be),    32'h0);

    run_op(32'h0000_2003, 32'h0000_00A5, 4'b0001, 1'b0, 3'd0, 2, 32'h1234_5678);
    chk("sb_addr",  obs_addr,       32'h0000_2000);
    chk("sb_be",    32'(obs_be),    32'h8);
    chk("sb_wdata", obs_wdata,      32'hA500_0000);
    chk("sb_we",    32'(obs_we),    32'h1);

    run_op(32'h0001_0002, 32'h0, 4'b0000, 1'b1, 3'd1, 1, 32'h0080_FF00);
    chk("lb_result", obs_result, 32'hFFFF_FF80);
    run_op(32'h0001_0002, 32'h0, 4'b0000, 1'b1, 3'd4, 1, 32'h0080_FF00);
    chk("lbu_result", obs_result, 32'h0000_0080);

    run_op(32'h0000_3002, 32'h1111_2222, 4'b1111, 1'b0, 3'd0, 1, 32'h0);
    chk("sw_mis_pulses", 32'(mis_cnt),   32'd1);
    chk("sw_mis_req",    32'(req_cnt),   32'd0);
    chk("sw_mis_stall",  32'(stall_cnt), 32'd0);

    run_op(32'h0000_4002, 32'h0, 4'b0000, 1'b1, 3'd2, 5, 32'h8001_0000);
    chk("lh_stall_cycles", 32'(stall_cnt), 32'd6);
    chk("lh_result",       obs_result,     32'hFFFF_8001);

    // Reset in the middle of a request abandons it at once.
    exp_on = 1'b0;
    AluOutM = 32'h0000_5000; StoreDataM = '0; MemWriteM = '0; MemToRegM = 1'b1; RegWriteM = 3'd3;
    mem_if.mem_ack = 1'b0;
    step();
    step();
    chk("busy_req_before_rst", 32'(mem_if.mem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_req",   32'(mem_if.mem_req), 32'h0);
    chk("rst_busy_stall", 32'(DmStall),        32'h0);
    chk("rst_busy_done",  32'(DmDoneM),        32'h0);
    chk("rst_busy_rdata", DmRdataM,            32'h0);
    step();
    step();
    rst_n = 1'b1;
    exp_on = 1'b1;
    run_op(32'h0000_5004, 32'h0, 4'b0000, 1'b1, 3'd3, 2, 32'h1234_5678);
    chk("post_rst_stall",  32'(stall_cnt), 32'd3);
    chk("post_rst_result", obs_result,     32'h1234_5678);

    for (int i = 0; i < 300; i++) begin
      kind  = $urandom_range(0, 9);
      addr  = $urandom;
      sdata = $urandom;
      word  = $urandom;
      lat   = $urandom_range(1, 4);
      lt    = 3'($urandom_range(1, 5));
      mtr   = 1'b1;
      mask  = 4'b0000;
      if (kind == 0) begin
        mtr = 1'b0;
        lt  = 3'($urandom_range(0, 7));
      end else if (kind <= 4) begin
        case ($urandom_range(0, 2))
          0:       mask = 4'b0001;
          1:       mask = 4'b0011;
          default: mask = 4'b1111;
        endcase
        mtr = 1'($urandom % 2);
      end else if (kind == 9) begin
        lt = 3'($urandom_range(0, 7));
      end
      sz = access_size(mask, lt);
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % sz);
      run_op(addr, sdata, mask, mtr, lt, lat, word);
    end

    exp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
